// File: rtl/nf_pkg.sv
// Shared constants and layout helpers for the NullFresh d=2 coordinate-function compression stage.
package nf_pkg;

    localparam int unsigned NCF    = 18;
    localparam int unsigned NSHARE = 3;

    // Components 0..8 and 9..17 each split into three consecutive triples, one per share.
    function automatic int unsigned cf_share(input int unsigned k);
        return (k < 9) ? (k / 3) : ((k - 9) / 3);
    endfunction

    function automatic logic [NCF-1:0] share_mask(input int unsigned s);
        logic [NCF-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < NCF; k++) begin
            if (cf_share(k) == s) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic int unsigned cf_idx(input int unsigned b, input int unsigned k);
        return b * NCF + k;
    endfunction

    function automatic int unsigned ys_idx(input int unsigned b, input int unsigned s);
        return b * NSHARE + s;
    endfunction

endpackage

// File: rtl/nf_compress_bit.sv
// Pure XOR compression of one bit's 18 coordinate-function outputs into 3 shares.
module nf_compress_bit
    import nf_pkg::*;
(
    input  logic [NCF-1:0]    cf_i,
    output logic [NSHARE-1:0] share_o
);

    for (genvar s = 0; s < NSHARE; s++) begin : g_share
        assign share_o[s] = ^(cf_i & share_mask(s));
    end

endmodule

// File: rtl/nf_cf_compress_reg.sv
// Register-and-compress stage: glitch-barrier register on the CF outputs, XOR compression
// into 3 shares per bit, and a valid/ready pipeline toward the next round stage.
module nf_cf_compress_reg
    import nf_pkg::*;
#(
    parameter int unsigned NBITS   = 4,
    parameter int unsigned OUT_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NBITS*NCF-1:0]    cf_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NBITS*NSHARE-1:0] y_share
);

    logic                    rdy_q;
    logic                    v1_q;
    logic [NBITS*NCF-1:0]    r1_q;
    logic [NBITS*NSHARE-1:0] y_d;
    logic                    adv2;
    logic                    acc;

    assign in_ready = rdy_q & (~v1_q | adv2);
    assign acc      = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    // R1 keeps its contents when drained so the compression tree never sees a transient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_q <= '0;
            v1_q <= 1'b0;
        end else if (acc) begin
            r1_q <= cf_in;
            v1_q <= 1'b1;
        end else if (adv2) begin
            v1_q <= 1'b0;
        end
    end

    for (genvar b = 0; b < NBITS; b++) begin : g_bit
        nf_compress_bit u_cmp (
            .cf_i    (r1_q[cf_idx(b, 0) +: NCF]),
            .share_o (y_d[ys_idx(b, 0) +: NSHARE])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                    v2_q;
        logic [NBITS*NSHARE-1:0] r2_q;

        assign adv2 = ~v2_q | out_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r2_q <= '0;
                v2_q <= 1'b0;
            end else if (v1_q && adv2) begin
                r2_q <= y_d;
                v2_q <= 1'b1;
            end else if (out_ready) begin
                v2_q <= 1'b0;
            end
        end

        assign y_share   = r2_q;
        assign out_valid = v2_q;
    end else begin : g_out_comb
        assign adv2      = out_ready;
        assign y_share   = y_d;
        assign out_valid = v1_q;
    end

endmodule

// File: tb/tb_nf_cf_compress_reg.sv
// Directed bench for nf_cf_compress_reg; both OUT_REG builds share stimulus, one is observed at a time.
module tb_nf_cf_compress_reg;
    import nf_pkg::*;

    localparam int unsigned NB = 4;
    localparam int unsigned CW = NB * NCF;
    localparam int unsigned YW = NB * NSHARE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] cf_in;

    logic          ir_a, ov_a, ir_b, ov_b;
    logic [YW-1:0] y_a, y_b;

    nf_cf_compress_reg #(.NBITS(NB), .OUT_REG(1)) dut_reg (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .cf_in(cf_in),
        .out_valid(ov_a), .out_ready(out_ready), .y_share(y_a)
    );

    nf_cf_compress_reg #(.NBITS(NB), .OUT_REG(0)) dut_comb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b), .cf_in(cf_in),
        .out_valid(ov_b), .out_ready(out_ready), .y_share(y_b)
    );

    bit            use_reg;
    logic          in_ready, out_valid;
    logic [YW-1:0] y_share;
    assign in_ready  = use_reg ? ir_a : ir_b;
    assign out_valid = use_reg ? ov_a : ov_b;
    assign y_share   = use_reg ? y_a  : y_b;

    int unsigned n_vec;
    int unsigned n_err;

    logic [CW-1:0] vecs [4];
    logic [YW-1:0] exps [4];

    function automatic logic [YW-1:0] model(input logic [CW-1:0] v);
        logic [YW-1:0] y;
        y = '0;
        for (int b = 0; b < NB; b++)
            for (int s = 0; s < 3; s++)
                for (int j = 0; j < 3; j++)
                    y[b*3+s] = y[b*3+s] ^ v[b*18+3*s+j] ^ v[b*18+9+3*s+j];
        return y;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cf_in     = '0;
        rst_n     = 1'b0;
        tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_vec++;
        if (y_share !== '0) begin n_err++; $display("FAIL reset_y: got %h expected 000", y_share); end
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b expected 0", in_ready); end
        tick();
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge: got %b expected 1", in_ready); end
    endtask

    task automatic send_one(input logic [CW-1:0] v, input logic [YW-1:0] exp, input string name,
                            output logic [YW-1:0] got);
        int unsigned k;
        int unsigned lat;
        lat       = use_reg ? 2 : 1;
        in_valid  = 1'b1;
        cf_in     = v;
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
        tick();
        in_valid = 1'b0;
        k = 1;
        while (out_valid !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        n_vec++;
        if (k != lat) begin n_err++; $display("FAIL %s_latency: got %0d expected %0d", name, k, lat); end
        n_vec++;
        if (y_share !== exp) begin n_err++; $display("FAIL %s_data: got %h expected %h", name, y_share, exp); end
        got = y_share;
        tick();
    endtask

    task automatic test_single;
        logic [CW-1:0] v;
        logic [YW-1:0] got;
        v = '0; v[0] = 1'b1;
        send_one(v, 12'h001, "b0c0", got);
        v = '0; v[3*18+17] = 1'b1;
        send_one(v, 12'h800, "b3c17", got);
        v = '0; v[1*18+12] = 1'b1;
        send_one(v, 12'h010, "b1c12", got);
        v = '1;
        send_one(v, 12'h000, "all_ones", got);
    endtask

    task automatic test_parity;
        logic [CW-1:0] v;
        logic [YW-1:0] got;
        for (int i = 0; i < 4; i++) begin
            v[31:0]  = $urandom();
            v[63:32] = $urandom();
            v[71:64] = 8'($urandom());
            send_one(v, model(v), "rand", got);
            for (int b = 0; b < NB; b++) begin
                n_vec++;
                if ((^got[b*3 +: 3]) !== (^v[b*18 +: 18])) begin
                    n_err++;
                    $display("FAIL parity_bit%0d: got %b expected %b", b, ^got[b*3 +: 3], ^v[b*18 +: 18]);
                end
            end
        end
    endtask

    task automatic test_stall;
        int unsigned   sent, recv, stall_left;
        int            acc_at_drop;
        bit            seen, prev_stall;
        logic [YW-1:0] prev_y;
        sent = 0; recv = 0; stall_left = 0; acc_at_drop = -1;
        seen = 0; prev_stall = 0; prev_y = '0;
        for (int cyc = 0; cyc < 60 && recv < 4; cyc++) begin
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || y_share !== prev_y) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b y=%h expected v=1 y=%h", out_valid, y_share, prev_y);
                end
            end
            if (out_valid === 1'b1 && !seen) begin
                seen = 1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            in_valid = (sent < 4);
            cf_in    = (sent < 4) ? vecs[sent] : '0;
            #1;
            if (seen && in_valid && in_ready !== 1'b1 && acc_at_drop < 0) acc_at_drop = int'(sent);
            if (out_valid === 1'b1 && out_ready) begin
                n_vec++;
                if (y_share !== exps[recv]) begin
                    n_err++;
                    $display("FAIL stream_order%0d: got %h expected %h", recv, y_share, exps[recv]);
                end
                recv++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_y     = y_share;
            if (in_valid && in_ready === 1'b1) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (recv != 4) begin n_err++; $display("FAIL stream_count: got %0d expected 4", recv); end
        n_vec++;
        if (acc_at_drop != (use_reg ? 2 : 1)) begin
            n_err++;
            $display("FAIL ready_drop: got %0d accepts expected %0d", acc_at_drop, use_reg ? 2 : 1);
        end
    endtask

    task automatic test_reset_inflight;
        logic [YW-1:0] got;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cf_in     = vecs[0];
        tick();
        cf_in = vecs[1];
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL inflight_valid: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b expected 0", out_valid); end
        n_vec++;
        if (y_share !== '0) begin n_err++; $display("FAIL async_y: got %h expected 000", y_share); end
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL async_ready: got %b expected 0", in_ready); end
        tick();
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL release_ready: got %b expected 0", in_ready); end
        tick();
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_edge_ready: got %b expected 1", in_ready); end
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL dropped_valid: got %b expected 0", out_valid); end
        send_one(vecs[3], exps[3], "post_reset", got);
    endtask

    task automatic run_suite;
        test_reset();
        test_single();
        test_parity();
        test_reset();
        test_stall();
        test_reset_inflight();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cf_in = '0;
        vecs[0] = '0; vecs[0][0]      = 1'b1; exps[0] = 12'h001;
        vecs[1] = '0; vecs[1][3*18+17] = 1'b1; exps[1] = 12'h800;
        vecs[2] = '0; vecs[2][1*18+12] = 1'b1; exps[2] = 12'h010;
        vecs[3] = '0; vecs[3][2*18+4]  = 1'b1; exps[3] = 12'h080;
        use_reg = 1'b1;
        run_suite();
        use_reg = 1'b0;
        run_suite();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
